// File: rtl/stopwatch_timer_pkg.sv
// Package for the stopwatch timer: seconds field constants, step direction type
// and the seconds clamp used on preset load.
package stopwatch_timer_pkg;

`include "stopwatch_defs.vh"

  localparam int SEC_W = `SEC_W;
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(`SEC_MAX);

  typedef enum logic {
    STEP_UP   = `STEP_UP,
    STEP_DOWN = `STEP_DOWN
  } step_dir_e;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/stopwatch_defs.vh
// Shared stopwatch constants: seconds field width/limit and step-direction encodings.
`ifndef STOPWATCH_DEFS_VH
`define STOPWATCH_DEFS_VH

`define SEC_W     6
`define SEC_MAX   59
`define STEP_UP   1'b0
`define STEP_DOWN 1'b1

`endif

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler; tick is high on the cycle whose edge
// wraps the count back to zero. sync_zero overrides enable.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic sync_zero,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = enable && !sync_zero && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_zero) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Minutes:seconds up/down timer with built-in 1 s prescaler, preset load and sticky expiry.
// Optional lap capture registers enabled by defining STOPWATCH_LAP_CAPTURE_EN.
module stopwatch_timer
  import stopwatch_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MINUTE_MAX    = 99,
  parameter int MIN_W         = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             hold_count,
  input  logic             down_mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_minutes,
  input  logic [SEC_W-1:0] load_seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             sec_pulse,
  output logic             expired
`ifdef STOPWATCH_LAP_CAPTURE_EN
  ,
  input  logic             lap_capture,
  output logic [MIN_W-1:0] lap_minutes,
  output logic [SEC_W-1:0] lap_seconds,
  output logic             lap_valid
`endif
);

  localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MINUTE_MAX);

  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             pulse_q, pulse_d;
  logic             exp_q, exp_d;

  step_dir_e dir;
  logic      at_zero;
  logic      down_idle;
  logic      presc_zero;
  logic      tick;

  assign dir       = down_mode ? STEP_DOWN : STEP_UP;
  assign at_zero   = (min_q == '0) && (sec_q == '0);
  // A finished countdown parks the prescaler so no step or pulse can occur.
  assign down_idle = (dir == STEP_DOWN) && at_zero;
  assign presc_zero = clear || load || down_idle;

  tick_prescaler #(
    .DIV(TICKS_PER_SEC)
  ) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (!hold_count),
    .sync_zero(presc_zero),
    .tick     (tick)
  );

  always_comb begin
    min_d   = min_q;
    sec_d   = sec_q;
    exp_d   = exp_q;
    pulse_d = 1'b0;
    if (clear) begin
      min_d = '0;
      sec_d = '0;
      exp_d = 1'b0;
    end else if (load) begin
      min_d = (load_minutes > MIN_MAX) ? MIN_MAX : load_minutes;
      sec_d = clamp_sec(load_seconds);
      exp_d = 1'b0;
    end else if (tick) begin
      pulse_d = 1'b1;
      if (dir == STEP_UP) begin
        if (sec_q != SEC_MAX) begin
          sec_d = sec_q + 1'b1;
        end else begin
          sec_d = '0;
          if (min_q >= MIN_MAX) begin
            min_d = '0;
            exp_d = 1'b1;
          end else begin
            min_d = min_q + 1'b1;
          end
        end
      end else begin
        // tick is suppressed at 00:00, so the borrow branch always has min_q > 0.
        if (sec_q != '0) begin
          sec_d = sec_q - 1'b1;
          if ((min_q == '0) && (sec_q == SEC_W'(1))) begin
            exp_d = 1'b1;
          end
        end else begin
          sec_d = SEC_MAX;
          min_d = min_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_q   <= '0;
      sec_q   <= '0;
      pulse_q <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      min_q   <= min_d;
      sec_q   <= sec_d;
      pulse_q <= pulse_d;
      exp_q   <= exp_d;
    end
  end

  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign sec_pulse = pulse_q;
  assign expired   = exp_q;

`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic [MIN_W-1:0] lap_min_q, lap_min_d;
  logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
  logic             lap_vld_q, lap_vld_d;

  // Capture samples the registered time, so a coincident step is not included.
  always_comb begin
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    lap_vld_d = lap_vld_q;
    if (clear) begin
      lap_min_d = '0;
      lap_sec_d = '0;
      lap_vld_d = 1'b0;
    end else if (lap_capture) begin
      lap_min_d = min_q;
      lap_sec_d = sec_q;
      lap_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lap_min_q <= '0;
      lap_sec_q <= '0;
      lap_vld_q <= 1'b0;
    end else begin
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
      lap_vld_q <= lap_vld_d;
    end
  end

  assign lap_minutes = lap_min_q;
  assign lap_seconds = lap_sec_q;
  assign lap_valid   = lap_vld_q;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Self-checking bench for stopwatch_timer: directed scenarios plus randomized
// traffic against a total-seconds reference model. Lap checks need STOPWATCH_LAP_CAPTURE_EN.
module tb_stopwatch_timer;

  localparam int TPS  = 4;
  localparam int MMAX = 2;
  localparam int MW   = 7;
  localparam int SPAN = (MMAX + 1) * 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          hold = 1'b0;
  logic          down = 1'b0;
  logic          load = 1'b0;
  logic [MW-1:0] lmin = '0;
  logic [5:0]    lsec = '0;
  logic [MW-1:0] minutes;
  logic [5:0]    seconds;
  logic          sec_pulse;
  logic          expired;
`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic          lap_capture = 1'b0;
  logic [MW-1:0] lap_minutes;
  logic [5:0]    lap_seconds;
  logic          lap_valid;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: time as total seconds, prescaler as plain integer.
  int m_t = 0, m_pre = 0, m_exp = 0, m_pulse = 0;
  int m_lap_t = 0, m_lap_v = 0;

  always #5 clk = ~clk;

  stopwatch_timer #(
    .TICKS_PER_SEC(TPS),
    .MINUTE_MAX   (MMAX),
    .MIN_W        (MW)
  ) dut (
    .clock       (clk),
    .reset_n     (rst_n),
    .clear       (clear),
    .hold_count  (hold),
    .down_mode   (down),
    .load        (load),
    .load_minutes(lmin),
    .load_seconds(lsec),
    .minutes     (minutes),
    .seconds     (seconds),
    .sec_pulse   (sec_pulse),
    .expired     (expired)
`ifdef STOPWATCH_LAP_CAPTURE_EN
    ,
    .lap_capture (lap_capture),
    .lap_minutes (lap_minutes),
    .lap_seconds (lap_seconds),
    .lap_valid   (lap_valid)
`endif
  );

  task automatic model_reset();
    m_t = 0; m_pre = 0; m_exp = 0; m_pulse = 0; m_lap_t = 0; m_lap_v = 0;
  endtask

  // One clock edge: advance the model with the inputs seen at that edge, then settle.
  task automatic cycle();
    int mm, ss;
    @(posedge clk);
    m_pulse = 0;
`ifdef STOPWATCH_LAP_CAPTURE_EN
    if (lap_capture) begin m_lap_t = m_t; m_lap_v = 1; end
`endif
    if (clear) begin
      m_t = 0; m_pre = 0; m_exp = 0; m_lap_t = 0; m_lap_v = 0;
    end else if (load) begin
      mm = (int'(lmin) > MMAX) ? MMAX : int'(lmin);
      ss = (int'(lsec) > 59) ? 59 : int'(lsec);
      m_t = mm * 60 + ss; m_pre = 0; m_exp = 0;
    end else if (down && m_t == 0) begin
      m_pre = 0;
    end else if (!hold) begin
      if (m_pre == TPS - 1) begin
        m_pre = 0;
        m_pulse = 1;
        if (down) m_t = m_t - 1;
        else m_t = (m_t + 1) % SPAN;
        if (m_t == 0) m_exp = 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({minutes, seconds, sec_pulse, expired} !== '0) begin
      bad++; $display("FAIL reset_async: got %0d:%0d p=%b e=%b want 0:0 p=0 e=0", minutes, seconds, sec_pulse, expired);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({minutes, seconds, sec_pulse, expired} !== '0) begin
      bad++; $display("FAIL reset_hold: got %0d:%0d p=%b e=%b want 0:0 p=0 e=0", minutes, seconds, sec_pulse, expired);
    end
    model_reset();
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_count_up();
    int pulses = 0;
    repeat (244) begin cycle(); pulses += int'(sec_pulse); end
    total++;
    if (minutes !== 7'd1 || seconds !== 6'd1) begin
      bad++; $display("FAIL up_244: got %0d:%0d want 1:1", minutes, seconds);
    end
    total++;
    if (pulses !== 61) begin
      bad++; $display("FAIL up_pulses: got %0d want 61", pulses);
    end
    total++;
    if (expired !== 1'b0) begin
      bad++; $display("FAIL up_expired: got %b want 0", expired);
    end
    $display("test_count_up: %0d:%0d pulses=%0d", minutes, seconds, pulses);
  endtask

  task automatic test_wrap();
    load = 1'b1; lmin = 7'd2; lsec = 6'd59;
    cycle();
    load = 1'b0;
    total++;
    if (minutes !== 7'd2 || seconds !== 6'd59 || expired !== 1'b0) begin
      bad++; $display("FAIL load_259: got %0d:%0d e=%b want 2:59 e=0", minutes, seconds, expired);
    end
    repeat (4) cycle();
    total++;
    if (minutes !== 7'd0 || seconds !== 6'd0 || expired !== 1'b1 || sec_pulse !== 1'b1) begin
      bad++; $display("FAIL wrap: got %0d:%0d e=%b p=%b want 0:0 e=1 p=1", minutes, seconds, expired, sec_pulse);
    end
    repeat (4) cycle();
    total++;
    if (minutes !== 7'd0 || seconds !== 6'd1 || expired !== 1'b1) begin
      bad++; $display("FAIL wrap_sticky: got %0d:%0d e=%b want 0:1 e=1", minutes, seconds, expired);
    end
    $display("test_wrap: %0d:%0d e=%b", minutes, seconds, expired);
  endtask

  task automatic test_hold();
    int pulses = 0;
    repeat (2) cycle();
    hold = 1'b1;
    repeat (20) begin cycle(); pulses += int'(sec_pulse); end
    total++;
    if (seconds !== 6'd1 || minutes !== 7'd0 || pulses !== 0) begin
      bad++; $display("FAIL hold: got %0d:%0d pulses=%0d want 0:1 pulses=0", minutes, seconds, pulses);
    end
    hold = 1'b0;
    cycle();
    total++;
    if (seconds !== 6'd1 || sec_pulse !== 1'b0) begin
      bad++; $display("FAIL release_1: got s=%0d p=%b want s=1 p=0", seconds, sec_pulse);
    end
    cycle();
    total++;
    if (seconds !== 6'd2 || sec_pulse !== 1'b1) begin
      bad++; $display("FAIL release_2: got s=%0d p=%b want s=2 p=1", seconds, sec_pulse);
    end
    $display("test_hold: %0d:%0d", minutes, seconds);
  endtask

  task automatic test_countdown();
    int pulses = 0;
    down = 1'b1; load = 1'b1; lmin = 7'd0; lsec = 6'd2;
    cycle();
    load = 1'b0;
    repeat (4) cycle();
    total++;
    if (minutes !== 7'd0 || seconds !== 6'd1 || expired !== 1'b0) begin
      bad++; $display("FAIL down_1: got %0d:%0d e=%b want 0:1 e=0", minutes, seconds, expired);
    end
    repeat (4) cycle();
    total++;
    if (minutes !== 7'd0 || seconds !== 6'd0 || expired !== 1'b1) begin
      bad++; $display("FAIL down_0: got %0d:%0d e=%b want 0:0 e=1", minutes, seconds, expired);
    end
    repeat (100) begin cycle(); pulses += int'(sec_pulse); end
    total++;
    if (minutes !== 7'd0 || seconds !== 6'd0 || pulses !== 0 || expired !== 1'b1) begin
      bad++; $display("FAIL down_idle: got %0d:%0d pulses=%0d e=%b want 0:0 pulses=0 e=1", minutes, seconds, pulses, expired);
    end
    $display("test_countdown: %0d:%0d e=%b", minutes, seconds, expired);
  endtask

  task automatic test_clear_load();
    clear = 1'b1; load = 1'b1; lmin = 7'd1; lsec = 6'd30;
    cycle();
    clear = 1'b0; load = 1'b0;
    total++;
    if (minutes !== 7'd0 || seconds !== 6'd0 || expired !== 1'b0) begin
      bad++; $display("FAIL clear_over_load: got %0d:%0d e=%b want 0:0 e=0", minutes, seconds, expired);
    end
    load = 1'b1; lmin = 7'd0; lsec = 6'd63;
    cycle();
    total++;
    if (minutes !== 7'd0 || seconds !== 6'd59) begin
      bad++; $display("FAIL clamp_sec: got %0d:%0d want 0:59", minutes, seconds);
    end
    lmin = 7'd7; lsec = 6'd0;
    cycle();
    load = 1'b0;
    total++;
    if (minutes !== 7'd2 || seconds !== 6'd0) begin
      bad++; $display("FAIL clamp_min: got %0d:%0d want 2:0", minutes, seconds);
    end
    down = 1'b0;
    repeat (6) cycle();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({minutes, seconds, sec_pulse, expired} !== '0) begin
      bad++; $display("FAIL reset_mid: got %0d:%0d p=%b e=%b want 0:0 p=0 e=0", minutes, seconds, sec_pulse, expired);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    $display("test_clear_load: done");
  endtask

`ifdef STOPWATCH_LAP_CAPTURE_EN
  task automatic test_lap();
    repeat (15) cycle();
    total++;
    if (seconds !== 6'd3) begin
      bad++; $display("FAIL lap_pre: got s=%0d want 3", seconds);
    end
    lap_capture = 1'b1;
    cycle();
    lap_capture = 1'b0;
    total++;
    if (seconds !== 6'd4 || lap_minutes !== 7'd0 || lap_seconds !== 6'd3 || lap_valid !== 1'b1) begin
      bad++; $display("FAIL lap_capture: got s=%0d lap=%0d:%0d v=%b want s=4 lap=0:3 v=1", seconds, lap_minutes, lap_seconds, lap_valid);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    total++;
    if (lap_minutes !== 7'd0 || lap_seconds !== 6'd0 || lap_valid !== 1'b0) begin
      bad++; $display("FAIL lap_clear: got lap=%0d:%0d v=%b want 0:0 v=0", lap_minutes, lap_seconds, lap_valid);
    end
    $display("test_lap: done");
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      clear = ($urandom_range(0, 49) == 0);
      load  = ($urandom_range(0, 24) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) down = ~down;
      lmin = MW'($urandom_range(0, 7));
      lsec = 6'($urandom_range(0, 63));
`ifdef STOPWATCH_LAP_CAPTURE_EN
      lap_capture = ($urandom_range(0, 9) == 0);
`endif
      cycle();
      total++;
      if (minutes !== MW'(m_t / 60) || seconds !== 6'(m_t % 60) ||
          sec_pulse !== 1'(m_pulse) || expired !== 1'(m_exp)) begin
        bad++; errs++;
        $display("FAIL rand_%0d: got %0d:%0d p=%b e=%b want %0d:%0d p=%0d e=%0d",
                 i, minutes, seconds, sec_pulse, expired, m_t / 60, m_t % 60, m_pulse, m_exp);
      end
`ifdef STOPWATCH_LAP_CAPTURE_EN
      total++;
      if (lap_minutes !== MW'(m_lap_t / 60) || lap_seconds !== 6'(m_lap_t % 60) || lap_valid !== 1'(m_lap_v)) begin
        bad++; errs++;
        $display("FAIL rand_lap_%0d: got %0d:%0d v=%b want %0d:%0d v=%0d",
                 i, lap_minutes, lap_seconds, lap_valid, m_lap_t / 60, m_lap_t % 60, m_lap_v);
      end
`endif
    end
    clear = 1'b0; load = 1'b0; hold = 1'b0;
`ifdef STOPWATCH_LAP_CAPTURE_EN
    lap_capture = 1'b0;
`endif
    $display("test_random: 600 cycles, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_hold();
    test_countdown();
    test_clear_load();
`ifdef STOPWATCH_LAP_CAPTURE_EN
    test_lap();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
